// File: rtl/tlc_timing_pkg.sv
// Shared timing constants for the traffic-light controller: system clock
// rate, default divider geometry and named divisors for common tick rates.
package tlc_timing_pkg;

   localparam int CLK_HZ          = 100_000;
   localparam int TLC_DIV_W       = 24;
   localparam int ONE_HZ_DIV      = CLK_HZ;
   localparam int BLINK_2HZ_DIV   = CLK_HZ / 2;
   localparam int TLC_DEFAULT_DIV = ONE_HZ_DIV;

endpackage

// File: rtl/tick_channel.sv
// One divider channel: period counter, active divisor, pending divisor and
// registered tick / square-wave outputs. A pending divisor only becomes
// active at a period wrap or a phase clear, so periods are never cut short.
module tick_channel
   import tlc_timing_pkg::*;
#(
   parameter int DIV_W       = TLC_DIV_W,
   parameter int DEFAULT_DIV = TLC_DEFAULT_DIV
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             clr_i,
   input  logic             wr_i,
   input  logic [DIV_W-1:0] wr_val_i,
   output logic             tick_o,
   output logic             sq_o
);

   logic [DIV_W-1:0] cnt_q,   cnt_d;
   logic [DIV_W-1:0] div_q,   div_d;
   logic [DIV_W-1:0] pend_q,  pend_d;
   logic             pendv_q, pendv_d;
   logic             tick_q,  tick_d;
   logic             sq_q,    sq_d;

   // Next-state: clear beats counting; a write lands after any pending value
   // has been consumed on this edge, so it stays pending for the next boundary.
   always_comb begin
      cnt_d   = cnt_q;
      div_d   = div_q;
      pend_d  = pend_q;
      pendv_d = pendv_q;
      tick_d  = 1'b0;
      sq_d    = sq_q;

      if (clr_i) begin
         cnt_d = '0;
         sq_d  = 1'b0;
         if (pendv_q) begin
            div_d   = pend_q;
            pendv_d = 1'b0;
         end
      end else if (en_i) begin
         if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            sq_d   = 1'b1;
            if (pendv_q) begin
               div_d   = pend_q;
               pendv_d = 1'b0;
            end
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (cnt_q + DIV_W'(1) == (div_q >> 1)) begin
               sq_d = 1'b0;
            end
         end
      end

      if (wr_i) begin
         pend_d  = wr_val_i;
         pendv_d = 1'b1;
      end
   end

   // State register with synchronous reset to the default divisor.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         div_q   <= DIV_W'(DEFAULT_DIV);
         pend_q  <= '0;
         pendv_q <= 1'b0;
         tick_q  <= 1'b0;
         sq_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         pend_q  <= pend_d;
         pendv_q <= pendv_d;
         tick_q  <= tick_d;
         sq_q    <= sq_d;
      end
   end

   assign tick_o = tick_q;
   assign sq_o   = sq_q;

endmodule

// File: rtl/multi_tick_divider.sv
// Multi-channel clock-enable divider. The top level only decodes divisor
// writes, rejects illegal ones (divisor < 2 or channel out of range) with a
// one-cycle wr_err pulse, and fans out to the per-channel counters.
module multi_tick_divider
   import tlc_timing_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = TLC_DIV_W,
   parameter int DEFAULT_DIV = TLC_DEFAULT_DIV,
   parameter int SEL_W       = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              Sync_Reset,
   input  logic              en,
   input  logic [NUM_CH-1:0] ch_clr,
   input  logic              div_wr,
   input  logic [SEL_W-1:0]  div_sel,
   input  logic [DIV_W-1:0]  div_val,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq,
   output logic              wr_err
);

   logic wr_ok;
   logic wr_err_q, wr_err_d;

   // Write legality check; the channel select compare is done as int so a
   // non-power-of-two channel count still rejects the unused codes.
   always_comb begin
      wr_ok    = (div_val >= DIV_W'(2)) && (int'(div_sel) < NUM_CH);
      wr_err_d = div_wr && !wr_ok;
   end

   // Rejected-write flag, a single-cycle pulse one cycle after the strobe.
   always_ff @(posedge clk) begin
      if (Sync_Reset) begin
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= wr_err_d;
      end
   end

   assign wr_err = wr_err_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      tick_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i    (clk),
         .rst_i    (Sync_Reset),
         .en_i     (en),
         .clr_i    (ch_clr[g]),
         .wr_i     (div_wr && wr_ok && (int'(div_sel) == g)),
         .wr_val_i (div_val),
         .tick_o   (tick[g]),
         .sq_o     (sq[g])
      );
   end

endmodule

// File: tb/tb_multi_tick_divider.sv
// Bench for multi_tick_divider (3 channels, 8-bit divisors, default 10).
// The reference model tracks each channel as "position within the period",
// current divisor, optional pending divisor and whether a wrap has been
// seen; tick and sq are derived from those quantities.
module tb_multi_tick_divider;

   localparam int NCH = 3;
   localparam int DW  = 8;
   localparam int DEF = 10;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           en = 1'b1;
   logic [NCH-1:0] ch_clr = '0;
   logic           div_wr = 1'b0;
   logic [1:0]     div_sel = '0;
   logic [DW-1:0]  div_val = '0;
   logic [NCH-1:0] tick, sq;
   logic           wr_err;

   multi_tick_divider #(.NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
      .clk        (clk),
      .Sync_Reset (rst),
      .en         (en),
      .ch_clr     (ch_clr),
      .div_wr     (div_wr),
      .div_sel    (div_sel),
      .div_val    (div_val),
      .tick       (tick),
      .sq         (sq),
      .wr_err     (wr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   // reference model state
   int       pos [NCH];
   int       dv  [NCH];
   int       pend[NCH];
   bit       started[NCH];
   logic [NCH-1:0] m_tick = '0;
   logic [NCH-1:0] m_sq   = '0;
   logic           m_err  = 1'b0;

   // Apply one clock edge's worth of behaviour to the model.
   task automatic model_edge();
      bit legal;
      m_tick = '0;
      m_err  = 1'b0;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            pos[c] = 0; dv[c] = DEF; pend[c] = -1; started[c] = 0;
         end
      end else begin
         legal = (int'(div_val) >= 2) && (int'(div_sel) < NCH);
         m_err = div_wr && !legal;
         for (int c = 0; c < NCH; c++) begin
            if (ch_clr[c]) begin
               pos[c] = 0;
               started[c] = 0;
               if (pend[c] >= 0) begin dv[c] = pend[c]; pend[c] = -1; end
            end else if (en) begin
               pos[c]++;
               if (pos[c] == dv[c]) begin
                  pos[c] = 0;
                  m_tick[c] = 1'b1;
                  started[c] = 1;
                  if (pend[c] >= 0) begin dv[c] = pend[c]; pend[c] = -1; end
               end
            end
            if (div_wr && legal && int'(div_sel) == c) pend[c] = int'(div_val);
         end
      end
      for (int c = 0; c < NCH; c++) m_sq[c] = started[c] && (pos[c] < dv[c] / 2);
   endtask

   // Advance one clock: update the model at the edge, then release the
   // one-shot strobes 1 time unit later (outputs are then settled).
   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      div_wr = 1'b0;
      ch_clr = '0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({wr_err, sq, tick} !== 7'b0) $display("FAIL reset_outputs got=%b want=%b", {wr_err, sq, tick}, 7'b0);
      else passes++;
      rst = 1'b0;
   endtask

   task automatic test_first_tick();
      int sq_hi;
      sq_hi = 0;
      for (int c = 1; c <= 20; c++) begin
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL first_tick cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (c == 10) begin
            checks++;
            if (tick !== 3'b111) $display("FAIL first_tick_cycle10 got=%b want=111", tick);
            else passes++;
         end
         if (c >= 10 && c <= 19 && sq[0]) sq_hi++;
      end
      checks++;
      if (sq_hi != 5) $display("FAIL sq_duty_10 got=%0d want=5", sq_hi);
      else passes++;
   endtask

   task automatic test_retime_ch1();
      int n, sq_hi;
      for (int k = 0; k < 20 && pos[1] != 3; k++) step();
      div_wr = 1'b1; div_sel = 2'd1; div_val = 8'd4;
      n = 0;
      for (int k = 0; k < 30; k++) begin
         step(); n++;
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL retime_ch1 cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (tick[1]) break;
      end
      checks++;
      if (n != 7) $display("FAIL retime_ch1_finish got=%0d want=7", n);
      else passes++;
      n = 0; sq_hi = 0;
      for (int k = 0; k < 30; k++) begin
         if (sq[1]) sq_hi++;
         step(); n++;
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL retime_ch1b cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (tick[1]) break;
      end
      checks++;
      if (n != 4 || sq_hi != 2) $display("FAIL retime_ch1_period got=%0d/%0d want=4/2", n, sq_hi);
      else passes++;
   endtask

   task automatic test_ch2_div7();
      int hi, lo, n;
      div_wr = 1'b1; div_sel = 2'd2; div_val = 8'd7;
      for (int k = 0; k < 40; k++) begin
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL ch2_div7 cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (tick[2] && dv[2] == 7) break;
      end
      hi = 0; lo = 0; n = 0;
      for (int k = 0; k < 30; k++) begin
         if (sq[2]) hi++; else lo++;
         step(); n++;
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL ch2_div7b cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (tick[2]) break;
      end
      checks++;
      if (n != 7 || hi != 3 || lo != 4) $display("FAIL ch2_div7_shape got=%0d/%0d/%0d want=7/3/4", n, hi, lo);
      else passes++;
   endtask

   task automatic test_wr_err();
      for (int t = 0; t < 2; t++) begin
         div_wr = 1'b1;
         div_sel = (t == 0) ? 2'd0 : 2'd3;
         div_val = (t == 0) ? 8'd1 : 8'd5;
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick} || wr_err !== 1'b1)
            $display("FAIL wr_err_pulse%0d got=%b want=%b", t, {wr_err, sq, tick}, {1'b1, m_sq, m_tick});
         else passes++;
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick} || wr_err !== 1'b0)
            $display("FAIL wr_err_width%0d got=%b want=%b", t, {wr_err, sq, tick}, {1'b0, m_sq, m_tick});
         else passes++;
      end
      for (int k = 0; k < 15; k++) begin
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL wr_err_after cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
      end
   endtask

   task automatic test_pause();
      logic [NCH-1:0] sq_frozen;
      int n;
      for (int k = 0; k < 20 && pos[0] != 6; k++) step();
      sq_frozen = sq;
      en = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         checks++;
         if (tick !== 3'b000 || sq !== sq_frozen || {wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL pause cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, sq_frozen, 3'b000});
         else passes++;
      end
      en = 1'b1;
      n = 0;
      for (int k = 0; k < 15; k++) begin
         step(); n++;
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL pause_resume cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
         if (tick[0]) break;
      end
      checks++;
      if (n != 4) $display("FAIL pause_resume_latency got=%0d want=4", n);
      else passes++;
   endtask

   task automatic test_pending_discard();
      int n;
      div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd5;
      step();
      rst = 1'b1;
      step();
      checks++;
      if ({wr_err, sq, tick} !== 7'b0) $display("FAIL reset_discard got=%b want=%b", {wr_err, sq, tick}, 7'b0);
      else passes++;
      rst = 1'b0;
      for (int p = 0; p < 2; p++) begin
         n = 0;
         for (int k = 0; k < 15; k++) begin
            step(); n++;
            checks++;
            if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
               $display("FAIL reset_period cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
            else passes++;
            if (tick[0]) break;
         end
         checks++;
         if (n != 10) $display("FAIL reset_period_len%0d got=%0d want=10", p, n);
         else passes++;
      end
      div_wr = 1'b1; div_sel = 2'd0; div_val = 8'd5;
      step();
      ch_clr = 3'b001;
      step();
      checks++;
      if (tick[0] !== 1'b0 || sq[0] !== 1'b0) $display("FAIL clr_outputs got=%b%b want=00", tick[0], sq[0]);
      else passes++;
      for (int p = 0; p < 2; p++) begin
         n = 0;
         for (int k = 0; k < 15; k++) begin
            step(); n++;
            checks++;
            if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
               $display("FAIL clr_apply cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
            else passes++;
            if (tick[0]) break;
         end
         checks++;
         if (n != 5) $display("FAIL clr_apply_len%0d got=%0d want=5", p, n);
         else passes++;
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 800; k++) begin
         en      = ($urandom_range(0, 7) != 0);
         div_wr  = ($urandom_range(0, 4) == 0);
         div_sel = 2'($urandom_range(0, 3));
         div_val = 8'($urandom_range(0, 12));
         for (int c = 0; c < NCH; c++) ch_clr[c] = ($urandom_range(0, 29) == 0);
         step();
         checks++;
         if ({wr_err, sq, tick} !== {m_err, m_sq, m_tick})
            $display("FAIL random cyc=%0d got=%b want=%b", cyc, {wr_err, sq, tick}, {m_err, m_sq, m_tick});
         else passes++;
      end
      en = 1'b1;
   endtask

   initial begin
      test_reset();
      test_first_tick();
      test_retime_ch1();
      test_ch2_div7();
      test_wr_err();
      test_pause();
      test_pending_discard();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule

// File: doc/multi_tick_divider.md
# multi_tick_divider

Parametrised multi-channel clock-enable divider for the traffic-light controller, generalising the fixed 1 Hz divider. It produces NUM_CH independent tick pulses and matching square waves from the single system clock. Each channel's divisor is run-time programmable, and changes take effect glitch-free at the channel's next period boundary. The controller FSM uses the tick outputs (state timers, blink rate, pedestrian countdown) as clock enables; nothing is ever clocked from them.

## Interface
- NUM_CH, 4, number of independent channels (≥2).
- DIV_W, 24, divisor and counter width.
- DEFAULT_DIV, 100_000, reset divisor for every channel: 1 Hz at the 100 kHz system clock. Legal range 2 ≤ DEFAULT_DIV < 2^DIV_W.
- SEL_W, $clog2(NUM_CH), width of div_sel (derived).

- clk  in  1  system clock, rising edge.
- Sync_Reset  in  1  synchronous, active-high reset.
- en  in  1  global run; low freezes all channels.
- ch_clr  in  NUM_CH  per-channel synchronous phase clear.
- div_wr  in  1  divisor write strobe.
- div_sel  in  SEL_W  channel addressed by div_wr.
- div_val  in  DIV_W  new divisor D.
- tick  out  NUM_CH  one-cycle pulse per period, registered.
- sq  out  NUM_CH  square wave, high floor(D/2) cycles, low ceil(D/2) cycles, registered.
- wr_err  out  1  one-cycle pulse on a rejected write.

## Operation
- One clock and one reset: synchronous, active-high Sync_Reset on clk. No asynchronous logic anywhere.
- Per-channel state: cnt (DIV_W), div (DIV_W), pend (DIV_W), pend_v (1), tick, sq.
- Reset values: cnt=0, div=DEFAULT_DIV, pend_v=0, tick=0, sq=0, wr_err=0.
- Priority per channel, per edge: Sync_Reset > ch_clr[i] > en counting.
- Counting (en=1):
  - If cnt==div-1: wrap. cnt←0, tick←1, sq←1. If pend_v, div←pend and pend_v←0.
  - Otherwise: cnt←cnt+1, tick←0. sq←0 when cnt+1==div/2 (floor), else sq holds.
- Pause (en=0): cnt and sq hold, tick←0. pend_v is not applied.
- ch_clr[i]=1: cnt←0, tick←0, sq←0. A valid pend is applied immediately (div←pend, pend_v←0).
- Divisor write, on div_wr=1:
  - Rejected if div_val<2 or div_sel≥NUM_CH. No state change; wr_err=1 on the next cycle.
  - Otherwise the addressed channel takes pend←div_val, pend_v←1.
  - A second write before the wrap overwrites pend; last write wins.
- Write on the same edge as a wrap: the wrap consumes the pre-edge pend_v/pend. The new value stays pending until the following wrap.
- Write on the same edge as ch_clr of the same channel: the clear applies the old pending value, if any. The new write becomes pending.
- First period after reset or ch_clr: sq stays low until the first wrap. From then on the duty cycle is as stated.
- Divisor is never applied mid-period, so no runt tick or runt sq phase occurs outside ch_clr/reset.

## Timing
- Period: exactly D en-high cycles between successive tick pulses. tick width is 1 cycle.
- After Sync_Reset is released with en=1 continuously, the first tick is high in the D-th cycle after release.
- All outputs are flops; no combinational path from inputs to outputs.
- wr_err is a 1-cycle pulse, latency 1.
- Divisor change latency: the current period always completes.
- Counter arithmetic is unsigned DIV_W. cnt never exceeds div-1, so no overflow.

## Structure
- Shared package tlc_timing_pkg holds:
  - DIV_W and DEFAULT_DIV defaults.
  - Clock-frequency constant CLK_HZ=100_000.
  - Named divisor constants (ONE_HZ_DIV, BLINK_2HZ_DIV).
- Sub-module tick_channel: one channel's cnt/div/pend/sq logic, instantiated NUM_CH times in a generate loop.
- Top level contains only write decode, range check and the wr_err flop.

## Test plan
Bench configuration: NUM_CH=3, DIV_W=8, DEFAULT_DIV=10, en=1 unless stated.
- Release reset, hold en=1 → every tick first high in cycle 10, then every 10 cycles. sq is 5 high / 5 low after the first wrap.
- Write ch1 D=4 when ch1 cnt=3 → ch1 completes its 10-cycle period, then ticks every 4 with sq 2/2. ch0 and ch2 are unchanged.
- Write ch2 D=7 → after the boundary, sq[2] is high 3, low 4; tick period is 7.
- Write div_val=1, then div_sel=3 → two wr_err pulses, each 1 cycle. No channel period changes.
- Drop en for 20 cycles when cnt=6 → no ticks and sq frozen. tick occurs 4 en-high cycles after en returns.
- Pending write ch0 D=5, then assert Sync_Reset before the wrap → pend discarded. Outputs are 0 on the next cycle and period returns to 10. Repeat with ch_clr[0] instead → D=5 takes effect immediately from cnt=0.
